cpu_core: RTL and testbench



---
 rtl/cpu_core.sv | 167 ++++++++++++++++
 tb/tb_cpu_core.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// Single-cycle 36-bit core with 18-bit instructions, plus its unified instruction/data memory.
// Latency: one instruction retires per clock; fetch and load data are combinational.
// Backpressure: none; the core never stalls, and only HALT or reset freeze state.

// Unified memory: 18-bit words, one combinational fetch port and one 36-bit data port.
module inst_mem #(
  parameter int DATA_WIDTH        = 36,
  parameter int INSTRUCTION_WIDTH = 18,
  parameter int ADDRESS_BUS_WIDTH = 14
) (
  input  logic                         i_clk,
  input  logic                         i_writeEnable,
  input  logic                         i_dataReadEnable,
  input  logic [DATA_WIDTH-1:0]        i_wdata,
  input  logic [ADDRESS_BUS_WIDTH-1:0] i_instr_address,
  input  logic [ADDRESS_BUS_WIDTH-1:0] i_data_address,
  output logic [INSTRUCTION_WIDTH-1:0] o_instruction,
  output logic [DATA_WIDTH-1:0]        o_data
);

  // Array name kept as "memory" so it can be preloaded hierarchically.
  logic [INSTRUCTION_WIDTH-1:0] memory [0:(2**ADDRESS_BUS_WIDTH)-1];

  // Second half of a 36-bit word lives at the next address, wrapping at the top.
  logic [ADDRESS_BUS_WIDTH-1:0] w_data_address_next;
  assign w_data_address_next = i_data_address + ADDRESS_BUS_WIDTH'(1);

  // Store both halves on the write edge; high half at the lower address.
  always_ff @(posedge i_clk) begin
    if (i_writeEnable) begin
      memory[i_data_address]      <= i_wdata[DATA_WIDTH-1:INSTRUCTION_WIDTH];
      memory[w_data_address_next] <= i_wdata[INSTRUCTION_WIDTH-1:0];
    end
  end

  assign o_instruction = memory[i_instr_address];
  assign o_data        = i_dataReadEnable ? {memory[i_data_address], memory[w_data_address_next]}
                                          : '0;

endmodule

// Processor core: decode, register file, ALU, branch unit and memory strobes.
module cpu_core #(
  parameter int DATA_WIDTH        = 36,
  parameter int INSTRUCTION_WIDTH = 18,
  parameter int ADDRESS_BUS_WIDTH = 14
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [INSTRUCTION_WIDTH-1:0] i_instruction,
  input  logic [DATA_WIDTH-1:0]        i_data_mem,
  output logic [DATA_WIDTH-1:0]        o_data_write,
  output logic [ADDRESS_BUS_WIDTH-1:0] o_instr_addr,
  output logic [ADDRESS_BUS_WIDTH-1:0] o_data_addr,
  output logic                         o_mem_write,
  output logic                         o_mem_read
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_AND  = 4'h3,
    OP_OR   = 4'h4, OP_XOR  = 4'h5, OP_SLT  = 4'h6, OP_SLL  = 4'h7,
    OP_SRL  = 4'h8, OP_ADDI = 4'h9, OP_LD   = 4'hA, OP_ST   = 4'hB,
    OP_BEQ  = 4'hC, OP_BNE  = 4'hD, OP_JMP  = 4'hE, OP_HALT = 4'hF
  } opcode_t;

  logic [ADDRESS_BUS_WIDTH-1:0] r_pc;
  logic                         r_halt;
  logic [DATA_WIDTH-1:0]        r_regs [0:7];

  opcode_t                      w_op;
  logic [2:0]                   w_rd, w_rs, w_rt;
  logic [7:0]                   w_imm8;
  logic [5:0]                   w_shamt;
  logic [DATA_WIDTH-1:0]        w_sext;
  logic [DATA_WIDTH-1:0]        w_rd_val, w_rs_val, w_rt_val;
  logic [ADDRESS_BUS_WIDTH-1:0] w_ea;
  logic [ADDRESS_BUS_WIDTH-1:0] w_pc_inc, w_br_target, w_pc_next;
  logic [DATA_WIDTH-1:0]        w_result;
  logic                         w_wen;
  logic                         w_active;

  assign w_op    = opcode_t'(i_instruction[17:14]);
  assign w_rd    = i_instruction[13:11];
  assign w_rs    = i_instruction[10:8];
  assign w_rt    = i_instruction[7:5];
  assign w_imm8  = i_instruction[7:0];
  assign w_shamt = w_imm8[5:0];
  assign w_sext  = {{(DATA_WIDTH-8){w_imm8[7]}}, w_imm8};

  // r0 is hard-wired to zero on the read side as well as ignored on writes.
  assign w_rd_val = (w_rd == 3'd0) ? '0 : r_regs[w_rd];
  assign w_rs_val = (w_rs == 3'd0) ? '0 : r_regs[w_rs];
  assign w_rt_val = (w_rt == 3'd0) ? '0 : r_regs[w_rt];

  // Effective address only needs the low bits; wraps naturally at 2^14.
  assign w_ea        = w_rs_val[ADDRESS_BUS_WIDTH-1:0] + w_sext[ADDRESS_BUS_WIDTH-1:0];
  assign w_pc_inc    = r_pc + ADDRESS_BUS_WIDTH'(1);
  assign w_br_target = w_pc_inc + w_sext[ADDRESS_BUS_WIDTH-1:0];

  // ALU result and register write-enable for the current instruction.
  always_comb begin
    w_result = '0;
    w_wen    = 1'b0;
    case (w_op)
      OP_ADD:  begin w_result = w_rs_val + w_rt_val; w_wen = 1'b1; end
      OP_SUB:  begin w_result = w_rs_val - w_rt_val; w_wen = 1'b1; end
      OP_AND:  begin w_result = w_rs_val & w_rt_val; w_wen = 1'b1; end
      OP_OR:   begin w_result = w_rs_val | w_rt_val; w_wen = 1'b1; end
      OP_XOR:  begin w_result = w_rs_val ^ w_rt_val; w_wen = 1'b1; end
      OP_SLT:  begin
        w_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_rs_val) < $signed(w_rt_val))};
        w_wen    = 1'b1;
      end
      OP_SLL:  begin
        w_result = (w_shamt >= 6'd36) ? '0 : (w_rs_val << w_shamt);
        w_wen    = 1'b1;
      end
      OP_SRL:  begin
        w_result = (w_shamt >= 6'd36) ? '0 : (w_rs_val >> w_shamt);
        w_wen    = 1'b1;
      end
      OP_ADDI: begin w_result = w_rs_val + w_sext; w_wen = 1'b1; end
      OP_LD:   begin w_result = i_data_mem;         w_wen = 1'b1; end
      default: begin w_result = '0;                 w_wen = 1'b0; end
    endcase
  end

  // Next-PC selection: sequential, branch, jump, or hold on HALT.
  always_comb begin
    w_pc_next = w_pc_inc;
    case (w_op)
      OP_BEQ:  w_pc_next = (w_rd_val == w_rs_val) ? w_br_target : w_pc_inc;
      OP_BNE:  w_pc_next = (w_rd_val != w_rs_val) ? w_br_target : w_pc_inc;
      OP_JMP:  w_pc_next = i_instruction[ADDRESS_BUS_WIDTH-1:0];
      OP_HALT: w_pc_next = r_pc;
      default: w_pc_next = w_pc_inc;
    endcase
  end

  // Strobes are suppressed during reset and once halted; buses are zeroed during reset.
  assign w_active     = !i_rst && !r_halt;
  assign o_mem_write  = w_active && (w_op == OP_ST);
  assign o_mem_read   = w_active && (w_op == OP_LD);
  assign o_data_write = i_rst ? '0 : w_rd_val;
  assign o_data_addr  = i_rst ? '0 : w_ea;
  assign o_instr_addr = r_pc;

  // Architectural state update: reset wins, HALT freezes everything until reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc   <= '0;
      r_halt <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= '0;
      end
    end else if (!r_halt) begin
      r_pc <= w_pc_next;
      if (w_wen && (w_rd != 3'd0)) begin
        r_regs[w_rd] <= w_result;
      end
      if (w_op == OP_HALT) begin
        r_halt <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core (bench acts as the memory) and for inst_mem.
// Directed vector table, HALT/reset sequences, then random instructions vs an ISA-level model.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [17:0] i_instruction;
  logic [35:0] i_data_mem;
  logic [35:0] o_data_write;
  logic [13:0] o_instr_addr;
  logic [13:0] o_data_addr;
  logic        o_mem_write;
  logic        o_mem_read;

  logic        m_we, m_re;
  logic [35:0] m_wdata;
  logic [13:0] m_iaddr, m_daddr;
  logic [17:0] m_instr;
  logic [35:0] m_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_core u_dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_instruction (i_instruction),
    .i_data_mem    (i_data_mem),
    .o_data_write  (o_data_write),
    .o_instr_addr  (o_instr_addr),
    .o_data_addr   (o_data_addr),
    .o_mem_write   (o_mem_write),
    .o_mem_read    (o_mem_read)
  );

  inst_mem u_mem (
    .i_clk            (clk),
    .i_writeEnable    (m_we),
    .i_dataReadEnable (m_re),
    .i_wdata          (m_wdata),
    .i_instr_address  (m_iaddr),
    .i_data_address   (m_daddr),
    .o_instruction    (m_instr),
    .o_data           (m_data)
  );

  typedef struct {
    logic [17:0] ins;
    logic [35:0] ld;
    logic [13:0] pc;
    logic [35:0] dw;
    logic [13:0] addr;
    logic        wr;
    logic        rd;
  } vec_t;

  vec_t vq[$];

  function automatic logic [17:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [17:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 5'b0};
  endfunction

  function automatic logic [17:0] enc_j(input logic [13:0] a);
    return {4'hE, a};
  endfunction

  task automatic add(input logic [17:0] ins, input logic [35:0] ld, input logic [13:0] pc,
                     input logic [35:0] dw, input logic [13:0] addr, input logic wr, input logic rd);
    vec_t v;
    v.ins = ins; v.ld = ld; v.pc = pc; v.dw = dw; v.addr = addr; v.wr = wr; v.rd = rd;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  // Present one instruction on the falling edge; outputs are valid 1 unit later.
  task automatic drive(input logic [17:0] ins, input logic [35:0] ld, input logic rst);
    @(negedge clk);
    i_instruction = ins;
    i_data_mem    = ld;
    i_rst         = rst;
    #1;
  endtask

  localparam logic [35:0] BIG = 36'h123456789;

  // Reference model state for the random phase
  logic [35:0] m_regs [0:7];
  logic [13:0] m_pc, npc, exp_addr;
  logic [3:0]  op;
  logic [17:0] ins;
  logic [35:0] ld, a, b, rdv, res, w36, hi_lo;
  logic [2:0]  rdi, rsi, rti;
  logic [7:0]  imm;
  int          simm;
  logic        wen;

  initial begin
    i_rst = 1'b1;
    i_instruction = enc_i(4'hB, 3'd7, 3'd3, 8'h55);
    i_data_mem = '0;
    m_we = 1'b0; m_re = 1'b0; m_wdata = '0; m_iaddr = '0; m_daddr = '0;

    // ---- reset state (a ST with nonzero fields is on the bus) ----
    drive(enc_i(4'hB, 3'd7, 3'd3, 8'h55), 36'd0, 1'b1);
    chk("rst pc",   36'(o_instr_addr), 36'd0);
    chk("rst dw",   o_data_write,      36'd0);
    chk("rst addr", 36'(o_data_addr),  36'd0);
    chk("rst wr",   36'(o_mem_write),  36'd0);
    chk("rst rd",   36'(o_mem_read),   36'd0);

    // ---- directed table: ins, load data, pc, rd value, data addr, wr, rd ----
    add(enc_i(4'h9,3'd1,3'd0,8'd5),    0,   14'd0,  0,    14'd5,    0,0); // ADDI r1,r0,5
    add(enc_i(4'h9,3'd2,3'd0,8'hFD),   0,   14'd1,  0,    14'h3FFD, 0,0); // ADDI r2,r0,-3
    add(enc_r(4'h1,3'd3,3'd1,3'd2),    0,   14'd2,  0,    14'd69,   0,0); // ADD r3,r1,r2
    add(enc_i(4'h0,3'd3,3'd0,8'd0),    0,   14'd3,  36'd2,14'd0,    0,0); // r3 == 2
    add(enc_i(4'hA,3'd1,3'd0,8'd10),   BIG, 14'd4,  36'd5,14'd10,   0,1); // LD r1
    add(enc_i(4'hB,3'd1,3'd0,8'd10),   0,   14'd5,  BIG,  14'd10,   1,0); // ST r1,10(r0)
    add(enc_i(4'hA,3'd4,3'd0,8'd10),   BIG, 14'd6,  0,    14'd10,   0,1); // LD r4,10(r0)
    add(enc_i(4'h0,3'd4,3'd0,8'd0),    0,   14'd7,  BIG,  14'd0,    0,0); // r4 == BIG
    add(enc_j(14'd4),                  0,   14'd8,  0,    14'd4,    0,0);
    add(enc_i(4'hC,3'd1,3'd1,8'd2),    0,   14'd4,  BIG,  14'h278B, 0,0); // BEQ taken
    add(enc_j(14'd4),                  0,   14'd7,  0,    14'd4,    0,0);
    add(enc_i(4'hD,3'd1,3'd1,8'd2),    0,   14'd4,  BIG,  14'h278B, 0,0); // BNE not taken
    add(enc_j(14'd4),                  0,   14'd5,  0,    14'd4,    0,0);
    add(enc_i(4'hC,3'd0,3'd0,8'hFB),   0,   14'd4,  0,    14'h3FFB, 0,0); // BEQ -5 -> 0
    add(enc_j(14'h3FFF),               0,   14'd0,  0,    14'h3FFF, 0,0);
    add(18'd0,                         0,   14'h3FFF,0,   14'd0,    0,0); // wraps to 0
    add(enc_i(4'h9,3'd0,3'd0,8'd7),    0,   14'd0,  0,    14'd7,    0,0); // ADDI r0 discarded
    add(enc_i(4'h9,3'd5,3'd0,8'd3),    0,   14'd1,  0,    14'd3,    0,0); // r5 = r0 + 3
    add(enc_i(4'h0,3'd5,3'd0,8'd0),    0,   14'd2,  36'd3,14'd0,    0,0);
    add(enc_i(4'h7,3'd6,3'd1,8'd35),   0,   14'd3,  0,    14'h27AC, 0,0); // SLL 35
    add(enc_i(4'h0,3'd6,3'd0,8'd0),    0,   14'd4,  36'h800000000, 14'd0, 0,0);
    add(enc_i(4'h7,3'd6,3'd1,8'd40),   0,   14'd5,  36'h800000000, 14'h27B1, 0,0); // SLL 40
    add(enc_i(4'h0,3'd6,3'd0,8'd0),    0,   14'd6,  0,    14'd0,    0,0);
    add(enc_i(4'h8,3'd6,3'd1,8'd4),    0,   14'd7,  0,    14'h278D, 0,0); // SRL 4
    add(enc_i(4'h0,3'd6,3'd0,8'd0),    0,   14'd8,  36'h012345678, 14'd0, 0,0);
    add(enc_i(4'h9,3'd2,3'd0,8'd1),    0,   14'd9,  36'hFFFFFFFFD, 14'd1, 0,0);
    add(enc_r(4'h2,3'd3,3'd0,3'd2),    0,   14'd10, 36'd2,14'd64,   0,0); // SUB 0-1
    add(enc_i(4'h0,3'd3,3'd0,8'd0),    0,   14'd11, 36'hFFFFFFFFF, 14'd0, 0,0);
    add(enc_r(4'h6,3'd4,3'd3,3'd0),    0,   14'd12, BIG,  14'h3FFF, 0,0); // SLT -1<0
    add(enc_i(4'h0,3'd4,3'd0,8'd0),    0,   14'd13, 36'd1,14'd0,    0,0);
    add(enc_r(4'h5,3'd5,3'd1,3'd6),    0,   14'd14, 36'd3,14'h2749, 0,0); // XOR
    add(enc_i(4'h0,3'd5,3'd0,8'd0),    0,   14'd15, 36'h1317131F1, 14'd0, 0,0);

    foreach (vq[i]) begin
      drive(vq[i].ins, vq[i].ld, 1'b0);
      chk($sformatf("vec%0d pc",   i), 36'(o_instr_addr), 36'(vq[i].pc));
      chk($sformatf("vec%0d dw",   i), o_data_write,      vq[i].dw);
      chk($sformatf("vec%0d addr", i), 36'(o_data_addr),  36'(vq[i].addr));
      chk($sformatf("vec%0d wr",   i), 36'(o_mem_write),  36'(vq[i].wr));
      chk($sformatf("vec%0d rd",   i), 36'(o_mem_read),   36'(vq[i].rd));
    end

    // ---- HALT at PC 16: PC frozen, no strobes, even with ST/LD on the bus ----
    drive(18'h3C000, 36'd0, 1'b0);
    chk("halt pc", 36'(o_instr_addr), 36'd16);
    for (int k = 0; k < 50; k++) begin
      drive({(k % 2 == 0) ? 4'hB : 4'hA, 14'($urandom)}, 36'($urandom), 1'b0);
      chk("halted pc", 36'(o_instr_addr), 36'd16);
      chk("halted wr", 36'(o_mem_write),  36'd0);
      chk("halted rd", 36'(o_mem_read),   36'd0);
    end

    // ---- reset clears halt; reset during a ST suppresses the write ----
    drive(enc_i(4'h0,3'd0,3'd0,8'd0), 36'd0, 1'b1);
    drive(enc_i(4'h9,3'd1,3'd0,8'd9), 36'd0, 1'b0);
    chk("post-halt pc", 36'(o_instr_addr), 36'd0);
    drive(enc_i(4'h0,3'd1,3'd0,8'd0), 36'd0, 1'b0);
    chk("post-halt pc advance", 36'(o_instr_addr), 36'd1);
    chk("post-halt r1", o_data_write, 36'd9);
    drive(enc_i(4'hB,3'd1,3'd0,8'd3), 36'd0, 1'b1);
    chk("rst-st wr", 36'(o_mem_write), 36'd0);
    drive(enc_i(4'h0,3'd1,3'd0,8'd0), 36'd0, 1'b0);
    chk("rst-st pc", 36'(o_instr_addr), 36'd0);
    chk("rst-st r1", o_data_write, 36'd0);

    // ---- random instructions against the ISA model ----
    drive(18'd0, 36'd0, 1'b1);
    m_pc = '0;
    for (int r = 0; r < 8; r++) m_regs[r] = '0;
    for (int n = 0; n < 400; n++) begin
      op  = 4'($urandom_range(0, 14));
      ins = {op, 14'($urandom)};
      ld  = {4'($urandom), 32'($urandom)};
      rdi = ins[13:11]; rsi = ins[10:8]; rti = ins[7:5]; imm = ins[7:0];
      simm = int'($signed(imm));
      a = m_regs[rsi]; b = m_regs[rti]; rdv = m_regs[rdi];
      exp_addr = 14'(longint'(a) + longint'(simm));
      drive(ins, ld, 1'b0);
      chk($sformatf("rnd%0d pc",   n), 36'(o_instr_addr), 36'(m_pc));
      chk($sformatf("rnd%0d dw",   n), o_data_write,      rdv);
      chk($sformatf("rnd%0d addr", n), 36'(o_data_addr),  36'(exp_addr));
      chk($sformatf("rnd%0d wr",   n), 36'(o_mem_write),  36'(op == 4'hB));
      chk($sformatf("rnd%0d rd",   n), 36'(o_mem_read),   36'(op == 4'hA));
      npc = 14'(int'(m_pc) + 1);
      res = '0;
      wen = (op >= 4'h1) && (op <= 4'hA);
      case (op)
        4'h1: res = a + b;
        4'h2: res = a - b;
        4'h3: res = a & b;
        4'h4: res = a | b;
        4'h5: res = a ^ b;
        4'h6: res = (longint'($signed(a)) < longint'($signed(b))) ? 36'd1 : 36'd0;
        4'h7: res = (imm[5:0] >= 6'd36) ? 36'd0 : 36'(a << imm[5:0]);
        4'h8: res = (imm[5:0] >= 6'd36) ? 36'd0 : (a >> imm[5:0]);
        4'h9: res = 36'(longint'(a) + longint'(simm));
        4'hA: res = ld;
        4'hC: if (rdv == a) npc = 14'(int'(m_pc) + 1 + simm);
        4'hD: if (rdv != a) npc = 14'(int'(m_pc) + 1 + simm);
        4'hE: npc = ins[13:0];
        default: ;
      endcase
      if (wen && rdi != 3'd0) m_regs[rdi] = res;
      m_pc = npc;
    end

    // ---- inst_mem: split storage, combinational fetch/read, gating, wraparound ----
    w36 = BIG;
    @(negedge clk);
    m_we = 1'b1; m_daddr = 14'd10; m_wdata = w36;
    @(negedge clk);
    m_we = 1'b0; m_iaddr = 14'd10; m_re = 1'b0;
    #1;
    chk("mem hi half", 36'(m_instr), 36'(w36[35:18]));
    chk("mem rd gated", m_data, 36'd0);
    m_iaddr = 14'd11; m_re = 1'b1;
    #1;
    chk("mem lo half", 36'(m_instr), 36'(w36[17:0]));
    chk("mem read36", m_data, w36);
    hi_lo = 36'hABCDE1234;
    @(negedge clk);
    m_we = 1'b1; m_daddr = 14'h3FFF; m_wdata = hi_lo;
    @(negedge clk);
    m_we = 1'b0; m_iaddr = 14'h3FFF;
    #1;
    chk("mem wrap hi", 36'(m_instr), 36'(hi_lo[35:18]));
    chk("mem wrap read36", m_data, hi_lo);
    m_iaddr = 14'd0;
    #1;
    chk("mem wrap lo", 36'(m_instr), 36'(hi_lo[17:0]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
